sram_secure_port_arbiter: RTL and testbench

//  Shares one 1rw combinational SRAM between two val/rdy requesters, such as a

---
 rtl/sram_secure_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sram_secure_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_secure_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single 1rw SRAM with a
// TrustZone-style partition. Entries at or above p_secure_base may only be
// touched by the secure domain. One access is in flight at a time. Each
// accepted access produces exactly one response on the granted port in the
// following cycle.
module sram_secure_port_arbiter #(
  parameter  int p_data_nbits  = 32,
  parameter  int p_num_entries = 256,
  parameter  int p_secure_base = 128,
  localparam int c_addr_nbits  = $clog2(p_num_entries),
  localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req0_val,
  output logic                     req0_rdy,
  input  logic                     req0_type,
  input  logic [c_addr_nbits-1:0]  req0_addr,
  input  logic [p_data_nbits-1:0]  req0_data,
  input  logic [c_data_nbytes-1:0] req0_byte_en,
  input  logic                     req0_domain,
  output logic                     resp0_val,
  input  logic                     resp0_rdy,
  output logic [p_data_nbits-1:0]  resp0_data,
  output logic                     resp0_err,

  input  logic                     req1_val,
  output logic                     req1_rdy,
  input  logic                     req1_type,
  input  logic [c_addr_nbits-1:0]  req1_addr,
  input  logic [p_data_nbits-1:0]  req1_data,
  input  logic [c_data_nbytes-1:0] req1_byte_en,
  input  logic                     req1_domain,
  output logic                     resp1_val,
  input  logic                     resp1_rdy,
  output logic [p_data_nbits-1:0]  resp1_data,
  output logic                     resp1_err,

  output logic                     sram_read_en,
  output logic [c_addr_nbits-1:0]  sram_read_addr,
  input  logic [p_data_nbits-1:0]  sram_read_data,
  output logic                     sram_write_en,
  output logic [c_data_nbytes-1:0] sram_write_byte_en,
  output logic [c_addr_nbits-1:0]  sram_write_addr,
  output logic [p_data_nbits-1:0]  sram_write_data,
  output logic                     sram_in_domain
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP0 = 2'd1,
    RESP1 = 2'd2
  } state_t;

  // Address compares are done at 32 bits so the out-of-range check stays
  // meaningful when the depth is not a power of two.
  localparam logic [31:0] c_secure_base = p_secure_base;
  localparam logic [31:0] c_num_entries = p_num_entries;

  state_t                   state;
  state_t                   state_next;
  logic                     prio;
  logic                     prio_next;
  logic [p_data_nbits-1:0]  resp_data_q;
  logic [p_data_nbits-1:0]  resp_data_next;
  logic                     resp_err_q;
  logic                     resp_err_next;

  logic                     grant_valid;
  logic                     grant;
  logic                     sel_type;
  logic [c_addr_nbits-1:0]  sel_addr;
  logic [p_data_nbits-1:0]  sel_data;
  logic [c_data_nbytes-1:0] sel_byte_en;
  logic                     sel_domain;
  logic [31:0]              addr_ext;
  logic                     deny;

  // Round-robin grant: the prio requester wins, otherwise the other one;
  // nothing is granted outside IDLE or while reset is held low.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (reset && (state == IDLE)) begin
      if (prio ? req1_val : req0_val) begin
        grant_valid = 1'b1;
        grant       = prio;
      end else if (prio ? req0_val : req1_val) begin
        grant_valid = 1'b1;
        grant       = ~prio;
      end
    end
  end

  // Select the granted request's fields and evaluate the partition check.
  always_comb begin
    sel_type    = grant ? req1_type    : req0_type;
    sel_addr    = grant ? req1_addr    : req0_addr;
    sel_data    = grant ? req1_data    : req0_data;
    sel_byte_en = grant ? req1_byte_en : req0_byte_en;
    sel_domain  = grant ? req1_domain  : req0_domain;
    addr_ext    = 32'(sel_addr);
    deny        = (sel_domain && (addr_ext >= c_secure_base)) ||
                  (addr_ext >= c_num_entries);
  end

  // Requester handshakes and SRAM drive; the SRAM is only touched in the accept cycle.
  always_comb begin
    req0_rdy           = grant_valid && !grant;
    req1_rdy           = grant_valid &&  grant;
    sram_read_en       = 1'b0;
    sram_write_en      = 1'b0;
    sram_read_addr     = '0;
    sram_write_addr    = '0;
    sram_write_data    = '0;
    sram_write_byte_en = '0;
    sram_in_domain     = 1'b0;
    if (grant_valid) begin
      sram_in_domain = sel_domain;
      sram_read_addr = sel_addr;
      if (!deny) begin
        if (sel_type) begin
          sram_write_en      = 1'b1;
          sram_write_addr    = sel_addr;
          sram_write_data    = sel_data;
          sram_write_byte_en = sel_byte_en;
        end else begin
          sram_read_en = 1'b1;
        end
      end
    end
  end

  // Response ports present the held response registers on the owning port.
  always_comb begin
    resp0_val  = reset && (state == RESP0);
    resp1_val  = reset && (state == RESP1);
    resp0_data = resp_data_q;
    resp1_data = resp_data_q;
    resp0_err  = resp_err_q;
    resp1_err  = resp_err_q;
  end

  // Next-state logic: accept moves to the granted port's response state, and
  // a consumed response returns to IDLE with priority handed to the other port.
  always_comb begin
    state_next     = state;
    prio_next      = prio;
    resp_data_next = resp_data_q;
    resp_err_next  = resp_err_q;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next     = grant ? RESP1 : RESP0;
          resp_err_next  = deny;
          resp_data_next = (!sel_type && !deny) ? sram_read_data : '0;
        end
      end
      RESP0: begin
        if (resp0_rdy) begin
          state_next = IDLE;
          prio_next  = 1'b1;
        end
      end
      RESP1: begin
        if (resp1_rdy) begin
          state_next = IDLE;
          prio_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, priority and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      prio        <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state       <= state_next;
      prio        <= prio_next;
      resp_data_q <= resp_data_next;
      resp_err_q  <= resp_err_next;
    end
  end

endmodule

// File: tb/tb_sram_secure_port_arbiter.sv
// Self-checking bench for sram_secure_port_arbiter: a behavioural SRAM,
// a table of single-access vectors, and hand-written multi-cycle sequences
// for arbitration, backpressure, reset and a randomized stress phase.
module tb_sram_secure_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_val, req0_rdy, req0_type, req0_domain;
  logic [7:0]  req0_addr;
  logic [31:0] req0_data;
  logic [3:0]  req0_byte_en;
  logic        resp0_val, resp0_rdy, resp0_err;
  logic [31:0] resp0_data;
  logic        req1_val, req1_rdy, req1_type, req1_domain;
  logic [7:0]  req1_addr;
  logic [31:0] req1_data;
  logic [3:0]  req1_byte_en;
  logic        resp1_val, resp1_rdy, resp1_err;
  logic [31:0] resp1_data;
  logic        sram_read_en, sram_write_en, sram_in_domain;
  logic [7:0]  sram_read_addr, sram_write_addr;
  logic [31:0] sram_read_data, sram_write_data;
  logic [3:0]  sram_write_byte_en;

  logic [31:0] mem [256];

  int compared   = 0;
  int mismatched = 0;

  sram_secure_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_type(req0_type),
    .req0_addr(req0_addr), .req0_data(req0_data), .req0_byte_en(req0_byte_en),
    .req0_domain(req0_domain),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_data(resp0_data),
    .resp0_err(resp0_err),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_type(req1_type),
    .req1_addr(req1_addr), .req1_data(req1_data), .req1_byte_en(req1_byte_en),
    .req1_domain(req1_domain),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_data(resp1_data),
    .resp1_err(resp1_err),
    .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr),
    .sram_read_data(sram_read_data),
    .sram_write_en(sram_write_en), .sram_write_byte_en(sram_write_byte_en),
    .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data),
    .sram_in_domain(sram_in_domain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: combinational read, byte-enabled synchronous write.
  assign sram_read_data = mem[sram_read_addr];
  always @(posedge clk) begin
    if (sram_write_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_write_byte_en[b]) mem[sram_write_addr][b*8 +: 8] <= sram_write_data[b*8 +: 8];
    end
  end

  typedef struct {
    int          port;
    logic        typ;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        dom;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int port, input logic val, input logic typ,
                           input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic dom);
    if (port == 0) begin
      req0_val = val; req0_type = typ; req0_addr = addr;
      req0_data = data; req0_byte_en = be; req0_domain = dom;
    end else begin
      req1_val = val; req1_type = typ; req1_addr = addr;
      req1_data = data; req1_byte_en = be; req1_domain = dom;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // One table access: wait for grant, check SRAM drive, then check the response.
  task automatic apply_vector(input vec_t v);
    int n = 0;
    drive_req(v.port, 1'b1, v.typ, v.addr, v.wdata, v.be, v.dom);
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    #1;
    while (!(v.port == 0 ? req0_rdy : req1_rdy) && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 10) begin
      check("grant_timeout", 32'(n), 32'(0));
      drive_req(v.port, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
      return;
    end
    check("vec_read_en", 32'(sram_read_en), 32'(v.exp_rd));
    check("vec_write_en", 32'(sram_write_en), 32'(v.exp_wr));
    check("vec_in_domain", 32'(sram_in_domain), 32'(v.dom));
    if (v.exp_wr) check("vec_write_addr", 32'(sram_write_addr), 32'(v.addr));
    @(posedge clk); #1;
    drive_req(v.port, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    #1;
    check("vec_resp_val", 32'(v.port == 0 ? resp0_val : resp1_val), 32'(1));
    check("vec_resp_data", v.port == 0 ? resp0_data : resp1_data, v.exp_data);
    check("vec_resp_err", 32'(v.port == 0 ? resp0_err : resp1_err), 32'(v.exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    bit          pending;
    int          exp_port;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        dny;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b0;
    drive_req(0, 1'b1, 1'b0, 8'h90, 32'h0, 4'h0, 1'b0);
    drive_req(1, 1'b1, 1'b1, 8'h10, 32'h1, 4'hF, 1'b1);
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;

    vecs[0]  = '{0, 1'b1, 8'h90, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{0, 1'b0, 8'h90, 32'h00000000, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1, 1'b0, 8'h90, 32'h00000000, 4'h0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{0, 1'b1, 8'h85, 32'h11223344, 4'hF, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1, 1'b1, 8'h85, 32'hAAAAAAAA, 4'hF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{0, 1'b0, 8'h85, 32'h00000000, 4'h0, 1'b0, 32'h11223344, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1, 1'b1, 8'h10, 32'hCAFEF00D, 4'h5, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1, 1'b0, 8'h10, 32'h00000000, 4'h0, 1'b1, 32'h00FE000D, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1, 1'b1, 8'h7F, 32'h12345678, 4'hF, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1, 1'b0, 8'h7F, 32'h00000000, 4'h0, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1, 1'b0, 8'h80, 32'h00000000, 4'h0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{0, 1'b1, 8'hFF, 32'hFFFF0000, 4'hC, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{0, 1'b0, 8'hFF, 32'h00000000, 4'h0, 1'b0, 32'hFFFF0000, 1'b0, 1'b1, 1'b0};

    // Reset held with both requests valid: everything stays quiet.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_req0_rdy", 32'(req0_rdy), 32'(0));
      check("rst_req1_rdy", 32'(req1_rdy), 32'(0));
      check("rst_resp0_val", 32'(resp0_val), 32'(0));
      check("rst_resp1_val", 32'(resp1_val), 32'(0));
      check("rst_read_en", 32'(sram_read_en), 32'(0));
      check("rst_write_en", 32'(sram_write_en), 32'(0));
    end
    drive_req(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    drive_req(1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) apply_vector(vecs[i]);

    // Both requesters saturating: grants alternate with one accept per 2 cycles.
    do_reset();
    drive_req(0, 1'b1, 1'b0, 8'h90, 32'h0, 4'h0, 1'b0);
    drive_req(1, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_req0_rdy", 32'(req0_rdy), 32'(k % 4 == 0));
      check("rr_req1_rdy", 32'(req1_rdy), 32'(k % 4 == 2));
      check("rr_resp0_val", 32'(resp0_val), 32'(k % 4 == 1));
      check("rr_resp1_val", 32'(resp1_val), 32'(k % 4 == 3));
      if (k % 4 == 1) check("rr_resp0_data", resp0_data, 32'hDEADBEEF);
      if (k % 4 == 2) check("rr_normal_read_en", 32'(sram_read_en), 32'(1));
      if (k % 4 == 3) begin
        check("rr_resp1_data", resp1_data, 32'h00FE000D);
        check("rr_resp1_err", 32'(resp1_err), 32'(0));
      end
      @(posedge clk); #1;
    end
    drive_req(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    drive_req(1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);

    // Response backpressure on port 0 for 5 cycles.
    do_reset();
    drive_req(0, 1'b1, 1'b0, 8'h90, 32'h0, 4'h0, 1'b0);
    drive_req(1, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
    resp0_rdy = 1'b0;
    resp1_rdy = 1'b1;
    #1;
    check("bp_req0_rdy", 32'(req0_rdy), 32'(1));
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("bp_resp0_val", 32'(resp0_val), 32'(1));
      check("bp_resp0_data", resp0_data, 32'hDEADBEEF);
      check("bp_req1_rdy", 32'(req1_rdy), 32'(0));
      if (k == 5) resp0_rdy = 1'b1;
      @(posedge clk); #1;
    end
    #1;
    check("bp_release_req1_rdy", 32'(req1_rdy), 32'(1));
    check("bp_release_req0_rdy", 32'(req0_rdy), 32'(0));
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    drive_req(1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    @(posedge clk); #1;

    // Reset while a port-1 response is pending drops it and restores prio 0.
    drive_req(1, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
    resp1_rdy = 1'b0;
    #1;
    check("mr_req1_rdy", 32'(req1_rdy), 32'(1));
    @(posedge clk); #1;
    drive_req(1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    #1;
    check("mr_resp1_val_pending", 32'(resp1_val), 32'(1));
    reset = 1'b0;
    @(posedge clk); #1;
    check("mr_resp1_val_dropped", 32'(resp1_val), 32'(0));
    check("mr_write_en", 32'(sram_write_en), 32'(0));
    drive_req(0, 1'b1, 1'b0, 8'h90, 32'h0, 4'h0, 1'b0);
    drive_req(1, 1'b1, 1'b1, 8'h10, 32'h77777777, 4'hF, 1'b1);
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    reset = 1'b1;
    #1;
    check("mr_prio_req0_rdy", 32'(req0_rdy), 32'(1));
    check("mr_prio_req1_rdy", 32'(req1_rdy), 32'(0));
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    drive_req(1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    #1;
    check("mr_resp0_val", 32'(resp0_val), 32'(1));
    check("mr_resp1_val", 32'(resp1_val), 32'(0));
    check("mr_mem_unchanged", mem[8'h10], 32'h00FE000D);
    @(posedge clk); #1;

    // Random val/rdy stress against a transaction-level reference.
    pending = 1'b0;
    exp_port = 0;
    exp_data = '0;
    exp_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      drive_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      drive_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      resp0_rdy = 1'($urandom_range(0, 1));
      resp1_rdy = 1'($urandom_range(0, 1));
      #1;
      check("st_rd_wr_exclusive", 32'(sram_read_en && sram_write_en), 32'(0));
      check("st_single_rdy", 32'(req0_rdy && req1_rdy), 32'(0));
      if (!req0_rdy && !req1_rdy) check("st_idle_domain", 32'(sram_in_domain), 32'(0));
      if (pending) begin
        check("st_no_rdy_busy", 32'(req0_rdy || req1_rdy), 32'(0));
        check("st_resp_val", 32'(exp_port == 0 ? resp0_val : resp1_val), 32'(1));
        check("st_other_resp_val", 32'(exp_port == 0 ? resp1_val : resp0_val), 32'(0));
        check("st_resp_data", exp_port == 0 ? resp0_data : resp1_data, exp_data);
        check("st_resp_err", 32'(exp_port == 0 ? resp0_err : resp1_err), 32'(exp_err));
        if (exp_port == 0 ? resp0_rdy : resp1_rdy) pending = 1'b0;
      end else begin
        check("st_resp_idle", 32'(resp0_val || resp1_val), 32'(0));
        check("st_grant_when_val", 32'(req0_rdy || req1_rdy), 32'(req0_val || req1_val));
        if (req0_val && req0_rdy) begin
          dny      = req0_domain && (req0_addr >= 8'h80);
          exp_port = 0;
          exp_err  = dny;
          exp_data = (!req0_type && !dny) ? mem[req0_addr] : 32'h0;
          pending  = 1'b1;
        end else if (req1_val && req1_rdy) begin
          dny      = req1_domain && (req1_addr >= 8'h80);
          exp_port = 1;
          exp_err  = dny;
          exp_data = (!req1_type && !dny) ? mem[req1_addr] : 32'h0;
          pending  = 1'b1;
        end
      end
      @(posedge clk); #1;
    end

    drive_req(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    drive_req(1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
